// File: rtl/lcd_frame_capture.sv
// Sink for the PPU pixel stream: captures one armed frame into a 160x144 2-bit frame store
// and exposes the store through a synchronous random-access read port.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | not capturing; beats consumed and discarded; waits for arm
// S_ARMED   | armed; discards beats until one carries pix_sof
// S_CAPTURE | storing beats in raster order until the last pixel of the frame

module lcd_frame_capture #(
   parameter int LINEWIDTH = 160,
   parameter int LINES     = 144,
   parameter int Y_BITS    = 8,
   parameter int X_BITS    = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              arm,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic              pix_sof,
   input  logic [1:0]        pix_data,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err,
   output logic [X_BITS-1:0] cur_x,
   output logic [Y_BITS-1:0] cur_y,
   input  logic              rd_en,
   input  logic [X_BITS-1:0] rd_x,
   input  logic [Y_BITS-1:0] rd_y,
   output logic [1:0]        rd_data
);

   localparam int DEPTH     = LINES * LINEWIDTH;
   localparam int ADDR_BITS = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   state_t state_q, state_nxt;

   logic [X_BITS-1:0]    x_nxt;
   logic [Y_BITS-1:0]    y_nxt;
   logic                 err_nxt;
   logic                 done_nxt;
   logic                 wr_en;
   logic                 wr_origin;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [ADDR_BITS-1:0] rd_addr;
   logic                 rd_in_range;
   logic                 beat;
   logic                 last_x;
   logic                 last_y;

   logic [1:0] mem [DEPTH];

   assign beat   = pix_valid & pix_ready;
   assign last_x = (cur_x == X_BITS'(LINEWIDTH - 1));
   assign last_y = (cur_y == Y_BITS'(LINES - 1));
   assign busy   = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cur_x      <= '0;
         cur_y      <= '0;
         frame_err  <= 1'b0;
         frame_done <= 1'b0;
         pix_ready  <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         cur_x      <= x_nxt;
         cur_y      <= y_nxt;
         frame_err  <= err_nxt;
         frame_done <= done_nxt;
         pix_ready  <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state_q;
      x_nxt     = cur_x;
      y_nxt     = cur_y;
      err_nxt   = frame_err;
      done_nxt  = 1'b0;
      wr_en     = 1'b0;
      wr_origin = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (arm) begin
               state_nxt = S_ARMED;
               err_nxt   = 1'b0;
               x_nxt     = '0;
               y_nxt     = '0;
            end
         end
         S_ARMED: begin
            if (beat && pix_sof) begin
               wr_en     = 1'b1;
               wr_origin = 1'b1;
               x_nxt     = X_BITS'(1);
               y_nxt     = '0;
               state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (beat) begin
               wr_en = 1'b1;
               if (pix_sof) begin
                  // A new frame started before this one ended: restart on it.
                  if ((cur_x != '0) || (cur_y != '0)) begin
                     err_nxt = 1'b1;
                  end
                  wr_origin = 1'b1;
                  x_nxt     = X_BITS'(1);
                  y_nxt     = '0;
               end else if (last_x) begin
                  x_nxt = '0;
                  if (last_y) begin
                     y_nxt    = '0;
                     done_nxt = 1'b1;
                     if (arm) begin
                        state_nxt = S_ARMED;
                        err_nxt   = 1'b0;
                     end else begin
                        state_nxt = S_IDLE;
                     end
                  end else begin
                     y_nxt = cur_y + 1'b1;
                  end
               end else begin
                  x_nxt = cur_x + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign wr_addr = wr_origin ? '0
                  : (ADDR_BITS'(cur_y) * ADDR_BITS'(LINEWIDTH) + ADDR_BITS'(cur_x));

   assign rd_in_range = (int'(rd_x) < LINEWIDTH) && (int'(rd_y) < LINES);
   assign rd_addr     = ADDR_BITS'(rd_y) * ADDR_BITS'(LINEWIDTH) + ADDR_BITS'(rd_x);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= pix_data;
      end
   end

   // Registered read returns the pre-write contents when addresses collide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= 2'd0;
      end else if (rd_en) begin
         rd_data <= rd_in_range ? mem[rd_addr] : 2'd0;
      end
   end

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Bench for lcd_frame_capture: directed frames with a read-port scoreboard and inline
// checks of the control outputs.

module tb_lcd_frame_capture;

   localparam int W = 160;
   localparam int H = 144;
   localparam int N = W * H;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       arm = 1'b0;
   logic       pix_valid = 1'b0;
   logic       pix_ready;
   logic       pix_sof = 1'b0;
   logic [1:0] pix_data = 2'd0;
   logic       busy;
   logic       frame_done;
   logic       frame_err;
   logic [7:0] cur_x;
   logic [7:0] cur_y;
   logic       rd_en = 1'b0;
   logic [7:0] rd_x = 8'd0;
   logic [7:0] rd_y = 8'd0;
   logic [1:0] rd_data;

   int n_pass = 0;
   int n_total = 0;
   int done_cnt = 0;
   logic rd_pend = 1'b0;
   logic [1:0] exp_q [$];

   always #5 clk = ~clk;

   lcd_frame_capture dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .arm        (arm),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_sof    (pix_sof),
      .pix_data   (pix_data),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .cur_x      (cur_x),
      .cur_y      (cur_y),
      .rd_en      (rd_en),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .rd_data    (rd_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [1:0] pat_a(input int i);
      return 2'(((i % W) + (i / W)) % 4);
   endfunction

   function automatic logic [1:0] pat_c(input int i);
      return 2'(3 - (((i % W) + (i / W)) % 4));
   endfunction

   // Scoreboard monitor: a read issued on one edge is compared at the next falling edge.
   always @(posedge clk) rd_pend <= rd_en;

   always @(negedge clk) begin
      if (frame_done === 1'b1) done_cnt++;
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            chk("rd_unexpected", 32'(rd_data), 32'hFFFF);
         end else begin
            chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic beat(input logic sof, input logic [1:0] d, input logic a);
      pix_valid = 1'b1;
      pix_sof   = sof;
      pix_data  = d;
      arm       = a;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      arm       = 1'b0;
      rd_en     = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      @(posedge clk);
      #1;
      arm = 1'b0;
   endtask

   task automatic rd(input int x, input int y, input logic [1:0] e);
      rd_en = 1'b1;
      rd_x  = 8'(x);
      rd_y  = 8'(y);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      rd_en = 1'b0;
   endtask

   task automatic drain();
      @(negedge clk);
      #1;
   endtask

   task automatic read_back_a();
      for (int a = 0; a < N; a += 7) rd(a % W, a / W, pat_a(a));
      rd(W - 1, H - 1, pat_a(N - 1));
      drain();
   endtask

   initial begin
      int base;
      #1;
      // Reset values
      chk("rst_pix_ready", 32'(pix_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(frame_done), 0);
      chk("rst_err", 32'(frame_err), 0);
      chk("rst_cur_x", 32'(cur_x), 0);
      chk("rst_cur_y", 32'(cur_y), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle_cycle();
      chk("ready_after_rst", 32'(pix_ready), 1);

      // T1: full frame, no gaps
      arm_pulse();
      chk("t1_busy_armed", 32'(busy), 1);
      for (int i = 0; i < N; i++) beat(i == 0, pat_a(i), 1'b0);
      chk("t1_done_pulse", 32'(frame_done), 1);
      chk("t1_busy_after", 32'(busy), 0);
      chk("t1_cur_x_after", 32'(cur_x), 0);
      chk("t1_cur_y_after", 32'(cur_y), 0);
      idle_cycle();
      chk("t1_done_one_cycle", 32'(frame_done), 0);
      chk("t1_done_cnt", 32'(done_cnt), 1);
      read_back_a();
      rd(1, 0, 2'd1);
      rd(200, 0, 2'd0);
      rd(0, 144, 2'd0);
      rd(159, 143, 2'd2);
      drain();
      repeat (3) idle_cycle();
      chk("rd_hold", 32'(rd_data), 2);

      // T2: beats while idle are discarded
      for (int i = 0; i < 300; i++) beat(i == 0, 2'd3, 1'b0);
      chk("t2_busy", 32'(busy), 0);
      chk("t2_done_cnt", 32'(done_cnt), 1);
      for (int a = 0; a < 300; a += 13) rd(a % W, a / W, pat_a(a));
      drain();

      // T3: pre-sof beats discarded, sof pixel lands at (0,0), colliding read sees old value
      arm_pulse();
      for (int i = 0; i < 100; i++) beat(1'b0, 2'd2, 1'b0);
      chk("t3_cur_x_armed", 32'(cur_x), 0);
      rd(5, 0, pat_a(5));
      rd_en = 1'b1;
      rd_x  = 8'd0;
      rd_y  = 8'd0;
      exp_q.push_back(2'd0);
      beat(1'b1, 2'd3, 1'b0);
      chk("t3_cur_x_sof", 32'(cur_x), 1);
      chk("t3_busy", 32'(busy), 1);
      rd(0, 0, 2'd3);
      for (int i = 1; i < 500; i++) beat(1'b0, pat_c(i), 1'b0);
      rd(1, 0, pat_c(1));
      chk("t3_cur_x_500", 32'(cur_x), 500 % W);
      chk("t3_cur_y_500", 32'(cur_y), 500 / W);

      // T4/T5: mid-frame sof restarts, full frame with gaps, arm on final pixel
      beat(1'b1, pat_a(0), 1'b0);
      chk("t4_err_set", 32'(frame_err), 1);
      chk("t4_cur_x", 32'(cur_x), 1);
      chk("t4_cur_y", 32'(cur_y), 0);
      chk("t4_no_done", 32'(done_cnt), 1);
      for (int i = 1; i < N; i++) begin
         if (i < 20 * W && $urandom_range(0, 1) == 1) begin
            idle_cycle();
            if (i == 160) begin
               chk("t5_hold_x", 32'(cur_x), 0);
               chk("t5_hold_y", 32'(cur_y), 1);
            end
         end
         beat(1'b0, pat_a(i), i == N - 1);
         if (i == 159) begin
            chk("t5_wrap_x", 32'(cur_x), 0);
            chk("t5_wrap_y", 32'(cur_y), 1);
         end
      end
      chk("t5_done_pulse", 32'(frame_done), 1);
      chk("t5_armed_busy", 32'(busy), 1);
      chk("t5_err_cleared", 32'(frame_err), 0);
      idle_cycle();
      chk("t5_done_cnt", 32'(done_cnt), 2);
      read_back_a();

      // T6: async reset partway through a frame
      base = done_cnt;
      for (int i = 0; i < 10000; i++) beat(i == 0, 2'd1, 1'b0);
      chk("t6_busy_pre", 32'(busy), 1);
      reset_n = 1'b0;
      #1;
      chk("t6_busy", 32'(busy), 0);
      chk("t6_cur_x", 32'(cur_x), 0);
      chk("t6_cur_y", 32'(cur_y), 0);
      chk("t6_ready", 32'(pix_ready), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle_cycle();
      chk("t6_no_done", 32'(done_cnt), base);
      chk("t6_done_low", 32'(frame_done), 0);
      rd(200, 0, 2'd0);
      drain();
      chk("sb_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
